tblink_call_queue: RTL and testbench

//  Upstream stage of a tblink interface-instance method executor (e.g. "inc", u32(i32)).
//  - Buffers incoming call requests (call id, method id, param) from the transport side.
//  - Dispatches them one at a time, in order, to the executor over valid/ready.
//  - Waits for the executor's result and emits one completion per call.
//  - Method ids outside the implemented range are completed with error and never dispatched.

---
 rtl/tblink_call_queue.sv | 204 ++++++++++++++++++++
 tb/tb_tblink_call_queue.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tblink_call_queue.sv
// tblink_call_queue: upstream stage of a tblink interface-instance method executor.
// It buffers call requests in a small FIFO and dispatches them to the executor one at a
// time, in order. It waits for each result and emits one completion per call.
// Method ids outside 0..NUM_METHODS-1 are completed with an error and never dispatched.
// Optional feature: define TBLINK_CALLQ_TIMEOUT_EN to enable a watchdog in WAIT_RSP.
// The watchdog completes a stalled call with an error after TIMEOUT cycles.
module tblink_call_queue #(
  parameter int DEPTH       = 4,
  parameter int NUM_METHODS = 1,
  parameter int MID_W       = 8,
  parameter int DATA_W      = 32,
  parameter int CID_W       = 32,
  parameter int TIMEOUT     = 1024
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [CID_W-1:0]         req_call_id,
  input  logic [MID_W-1:0]         req_method_id,
  input  logic [DATA_W-1:0]        req_param,
  output logic                     exe_valid,
  input  logic                     exe_ready,
  output logic [MID_W-1:0]         exe_method_id,
  output logic [DATA_W-1:0]        exe_param,
  input  logic                     rsp_valid,
  input  logic [DATA_W-1:0]        rsp_value,
  output logic                     cpl_valid,
  input  logic                     cpl_ready,
  output logic [CID_W-1:0]         cpl_call_id,
  output logic [DATA_W-1:0]        cpl_value,
  output logic                     cpl_error,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              done_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int MIDX_W = MID_W + 1;
  localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(DEPTH);
  localparam logic [MIDX_W-1:0] NUM_M    = MIDX_W'(NUM_METHODS);

  // Elaboration-time sanity checks on the configuration
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("tblink_call_queue: DEPTH must be a power of 2 and >= 2");
  end
  if (TIMEOUT < 1) begin : g_timeout_chk
    $error("tblink_call_queue: TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISP     = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_CPL      = 2'd3
  } state_e;

  // Request storage; no reset so it maps onto plain RAM
  logic [CID_W-1:0]  cid_mem   [DEPTH];
  logic [MID_W-1:0]  mid_mem   [DEPTH];
  logic [DATA_W-1:0] param_mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              push_d, pop_d, head_bad_d;

  state_e            state_q;
  logic              exe_valid_q;
  logic [MID_W-1:0]  exe_mid_q;
  logic [DATA_W-1:0] exe_param_q;
  logic [CID_W-1:0]  cid_q;
  logic              cpl_valid_q;
  logic [DATA_W-1:0] cpl_value_q;
  logic              cpl_error_q;
  logic [15:0]       done_count_q;

`ifdef TBLINK_CALLQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  logic [TO_W-1:0] to_cnt_q;
`endif

  // Push/pop decisions and next FIFO occupancy; a full FIFO never accepts, even while popping
  always_comb begin
    push_d     = req_valid && (level_q != FULL_LVL);
    pop_d      = (state_q == ST_IDLE) && (level_q != '0);
    head_bad_d = ({1'b0, mid_mem[rd_ptr_q]} >= NUM_M);
    level_d    = level_q;
    if (push_d && !pop_d) begin
      level_d = level_q + LVL_W'(1);
    end else if (!push_d && pop_d) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  // Request storage write port
  always_ff @(posedge clock) begin
    if (push_d) begin
      cid_mem[wr_ptr_q]   <= req_call_id;
      mid_mem[wr_ptr_q]   <= req_method_id;
      param_mem[wr_ptr_q] <= req_param;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally modulo DEPTH
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_d) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_d)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
    end
  end

  // Call sequencer: pop, dispatch, wait for result, hold completion until accepted
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      exe_valid_q  <= 1'b0;
      exe_mid_q    <= '0;
      exe_param_q  <= '0;
      cid_q        <= '0;
      cpl_valid_q  <= 1'b0;
      cpl_value_q  <= '0;
      cpl_error_q  <= 1'b0;
      done_count_q <= '0;
`ifdef TBLINK_CALLQ_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop_d) begin
            cid_q       <= cid_mem[rd_ptr_q];
            exe_mid_q   <= mid_mem[rd_ptr_q];
            exe_param_q <= param_mem[rd_ptr_q];
            if (head_bad_d) begin
              // Unknown method: complete immediately, executor never sees it
              cpl_valid_q <= 1'b1;
              cpl_error_q <= 1'b1;
              cpl_value_q <= '0;
              state_q     <= ST_CPL;
            end else begin
              exe_valid_q <= 1'b1;
              state_q     <= ST_DISP;
            end
          end
        end
        ST_DISP: begin
          // A result arriving on the handshake edge itself is deliberately dropped
          if (exe_ready) begin
            exe_valid_q <= 1'b0;
            state_q     <= ST_WAIT_RSP;
`ifdef TBLINK_CALLQ_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
          end
        end
        ST_WAIT_RSP: begin
          if (rsp_valid) begin
            cpl_valid_q <= 1'b1;
            cpl_error_q <= 1'b0;
            cpl_value_q <= rsp_value;
            state_q     <= ST_CPL;
`ifdef TBLINK_CALLQ_TIMEOUT_EN
          end else if (to_cnt_q == TO_LAST) begin
            // Watchdog expiry; a result in this same cycle takes priority above
            cpl_valid_q <= 1'b1;
            cpl_error_q <= 1'b1;
            cpl_value_q <= '0;
            state_q     <= ST_CPL;
          end else begin
            to_cnt_q    <= to_cnt_q + TO_W'(1);
`endif
          end
        end
        ST_CPL: begin
          if (cpl_ready) begin
            cpl_valid_q  <= 1'b0;
            cpl_error_q  <= 1'b0;
            done_count_q <= done_count_q + 16'd1;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready     = (level_q != FULL_LVL);
  assign level         = level_q;
  assign exe_valid     = exe_valid_q;
  assign exe_method_id = exe_mid_q;
  assign exe_param     = exe_param_q;
  assign cpl_valid     = cpl_valid_q;
  assign cpl_call_id   = cid_q;
  assign cpl_value     = cpl_value_q;
  assign cpl_error     = cpl_error_q;
  assign done_count    = done_count_q;

endmodule

// File: tb/tb_tblink_call_queue.sv
// Directed bench for tblink_call_queue (DEPTH=4, NUM_METHODS=1).
// With TBLINK_CALLQ_TIMEOUT_EN defined it also exercises the watchdog with TIMEOUT=16.
module tb_tblink_call_queue;
  localparam int DEPTH       = 4;
  localparam int NUM_METHODS = 1;
  localparam int MID_W       = 8;
  localparam int DATA_W      = 32;
  localparam int CID_W       = 32;
`ifdef TBLINK_CALLQ_TIMEOUT_EN
  localparam int TIMEOUT     = 16;
`else
  localparam int TIMEOUT     = 1024;
`endif

  logic              clock = 1'b0;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  logic [CID_W-1:0]  req_call_id;
  logic [MID_W-1:0]  req_method_id;
  logic [DATA_W-1:0] req_param;
  logic              exe_valid;
  logic              exe_ready;
  logic [MID_W-1:0]  exe_method_id;
  logic [DATA_W-1:0] exe_param;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_value;
  logic              cpl_valid;
  logic              cpl_ready;
  logic [CID_W-1:0]  cpl_call_id;
  logic [DATA_W-1:0] cpl_value;
  logic              cpl_error;
  logic [2:0]        level;
  logic [15:0]       done_count;

  int n_checks = 0;
  int n_errors = 0;

  tblink_call_queue #(
    .DEPTH(DEPTH), .NUM_METHODS(NUM_METHODS), .MID_W(MID_W),
    .DATA_W(DATA_W), .CID_W(CID_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_call_id(req_call_id),
    .req_method_id(req_method_id), .req_param(req_param),
    .exe_valid(exe_valid), .exe_ready(exe_ready),
    .exe_method_id(exe_method_id), .exe_param(exe_param),
    .rsp_valid(rsp_valid), .rsp_value(rsp_value),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_call_id(cpl_call_id),
    .cpl_value(cpl_value), .cpl_error(cpl_error),
    .level(level), .done_count(done_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic push(input logic [31:0] cid, input logic [7:0] mid, input logic [31:0] p);
    req_valid     = 1'b1;
    req_call_id   = cid;
    req_method_id = mid;
    req_param     = p;
    tick();
    req_valid     = 1'b0;
  endtask

  task automatic wait_exe(input int max_cycles);
    int k;
    k = 0;
    while (!exe_valid && k < max_cycles) begin
      tick();
      k++;
    end
    if (!exe_valid) chk("exe_wait_expired", 64'(exe_valid), 64'd1);
  endtask

  task automatic wait_cpl(input int max_cycles);
    int k;
    k = 0;
    while (!cpl_valid && k < max_cycles) begin
      tick();
      k++;
    end
    if (!cpl_valid) chk("cpl_wait_expired", 64'(cpl_valid), 64'd1);
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_call_id = '0; req_method_id = '0;
    req_param = '0; exe_ready = 1'b0; rsp_valid = 1'b0; rsp_value = '0; cpl_ready = 1'b0;
    tick(); tick();
    reset_n = 1'b1;

    // Reset state
    chk("rst_exe_valid", 64'(exe_valid), 64'd0);
    chk("rst_cpl_valid", 64'(cpl_valid), 64'd0);
    chk("rst_cpl_error", 64'(cpl_error), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_done", 64'(done_count), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_cpl_value", 64'(cpl_value), 64'd0);

    // 1: single good call, latency, handshake-edge rsp dropped, rsp in CPL ignored
    exe_ready = 1'b1;
    push(32'd7, 8'd0, 32'd41);
    chk("t1_level_after_push", 64'(level), 64'd1);
    chk("t1_exe_not_yet", 64'(exe_valid), 64'd0);
    tick();
    chk("t1_exe_valid_n2", 64'(exe_valid), 64'd1);
    chk("t1_exe_mid", 64'(exe_method_id), 64'd0);
    chk("t1_exe_param", 64'(exe_param), 64'd41);
    rsp_valid = 1'b1; rsp_value = 32'd99;
    tick();
    rsp_valid = 1'b0;
    chk("t1_exe_dropped", 64'(exe_valid), 64'd0);
    chk("t1_hs_rsp_ignored", 64'(cpl_valid), 64'd0);
    tick();
    chk("t1_no_cpl_yet", 64'(cpl_valid), 64'd0);
    rsp_valid = 1'b1; rsp_value = 32'd42;
    tick();
    rsp_valid = 1'b0;
    chk("t1_cpl_valid", 64'(cpl_valid), 64'd1);
    chk("t1_cpl_id", 64'(cpl_call_id), 64'd7);
    chk("t1_cpl_value", 64'(cpl_value), 64'd42);
    chk("t1_cpl_error", 64'(cpl_error), 64'd0);
    rsp_valid = 1'b1; rsp_value = 32'd55;
    tick();
    rsp_valid = 1'b0;
    chk("t1_cpl_rsp_ignored", 64'(cpl_value), 64'd42);
    cpl_ready = 1'b1;
    tick();
    cpl_ready = 1'b0;
    chk("t1_cpl_cleared", 64'(cpl_valid), 64'd0);
    chk("t1_done", 64'(done_count), 64'd1);

    // 2: unknown method id completes with error, never dispatched
    push(32'd3, 8'd5, 32'h123);
    chk("t2_exe_idle_a", 64'(exe_valid), 64'd0);
    chk("t2_no_cpl_yet", 64'(cpl_valid), 64'd0);
    tick();
    chk("t2_exe_idle_b", 64'(exe_valid), 64'd0);
    chk("t2_cpl_valid", 64'(cpl_valid), 64'd1);
    chk("t2_cpl_error", 64'(cpl_error), 64'd1);
    chk("t2_cpl_value", 64'(cpl_value), 64'd0);
    chk("t2_cpl_id", 64'(cpl_call_id), 64'd3);
    cpl_ready = 1'b1;
    tick();
    cpl_ready = 1'b0;
    chk("t2_exe_idle_c", 64'(exe_valid), 64'd0);
    chk("t2_done", 64'(done_count), 64'd2);

    // 3: fill with executor stalled; first request sits in DISP, four fill the FIFO
    exe_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(32'(10 + i), 8'd0, 32'(100 + i));
    chk("t3_level_full", 64'(level), 64'd4);
    chk("t3_req_ready", 64'(req_ready), 64'd0);
    chk("t3_exe_head", 64'(exe_param), 64'd100);
    push(32'd15, 8'd0, 32'd105);
    chk("t3_no_push_when_full", 64'(level), 64'd4);

    // 3/4: release; each call answered with param+1, completions in push order
    exe_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_exe(8);
      chk("t3_exe_param_order", 64'(exe_param), 64'(100 + i));
      tick();
      rsp_valid = 1'b1; rsp_value = 32'(101 + i);
      tick();
      rsp_valid = 1'b0;
      wait_cpl(4);
      chk("t3_cpl_id_order", 64'(cpl_call_id), 64'(10 + i));
      chk("t3_cpl_value", 64'(cpl_value), 64'(101 + i));
      if (i == 0) begin
        for (int c = 0; c < 10; c++) begin
          tick();
          chk("t4_hold_valid", 64'(cpl_valid), 64'd1);
          chk("t4_hold_id", 64'(cpl_call_id), 64'd10);
          chk("t4_hold_value", 64'(cpl_value), 64'd101);
          chk("t4_no_dispatch", 64'(exe_valid), 64'd0);
          chk("t4_level_held", 64'(level), 64'd4);
        end
      end
      cpl_ready = 1'b1;
      tick();
      cpl_ready = 1'b0;
    end
    chk("t3_done", 64'(done_count), 64'd7);
    chk("t3_level_empty", 64'(level), 64'd0);

    // 5: reset while waiting with two queued; later rsp must be ignored
    push(32'd20, 8'd0, 32'd1);
    push(32'd21, 8'd0, 32'd2);
    push(32'd22, 8'd0, 32'd3);
    chk("t5_level_2", 64'(level), 64'd2);
    chk("t5_in_wait", 64'(exe_valid), 64'd0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    rsp_valid = 1'b1; rsp_value = 32'd77;
    tick();
    rsp_valid = 1'b0;
    tick();
    chk("t5_level", 64'(level), 64'd0);
    chk("t5_no_cpl", 64'(cpl_valid), 64'd0);
    chk("t5_exe_valid", 64'(exe_valid), 64'd0);
    chk("t5_done", 64'(done_count), 64'd0);
    chk("t5_cpl_value", 64'(cpl_value), 64'd0);
    chk("t5_cpl_id", 64'(cpl_call_id), 64'd0);
    chk("t5_exe_param", 64'(exe_param), 64'd0);

`ifdef TBLINK_CALLQ_TIMEOUT_EN
    // 6a: no response -> error completion after exactly TIMEOUT cycles in WAIT_RSP
    begin
      int k;
      push(32'd30, 8'd0, 32'd5);
      wait_exe(8);
      tick();
      k = 0;
      while (!cpl_valid && k < 40) begin
        tick();
        k++;
      end
      chk("t6_timeout_cycles", 64'(k), 64'd16);
      chk("t6_timeout_error", 64'(cpl_error), 64'd1);
      chk("t6_timeout_value", 64'(cpl_value), 64'd0);
      chk("t6_timeout_id", 64'(cpl_call_id), 64'd30);
      cpl_ready = 1'b1;
      tick();
      cpl_ready = 1'b0;
    end
    // 6b: response in the expiry cycle wins
    push(32'd31, 8'd0, 32'd6);
    wait_exe(8);
    tick();
    for (int c = 0; c < 15; c++) tick();
    chk("t6_no_early_cpl", 64'(cpl_valid), 64'd0);
    rsp_valid = 1'b1; rsp_value = 32'hABC;
    tick();
    rsp_valid = 1'b0;
    chk("t6_expiry_cpl", 64'(cpl_valid), 64'd1);
    chk("t6_expiry_error", 64'(cpl_error), 64'd0);
    chk("t6_expiry_value", 64'(cpl_value), 64'hABC);
    cpl_ready = 1'b1;
    tick();
    cpl_ready = 1'b0;
    chk("t6_done", 64'(done_count), 64'd2);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
